// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM responder: word-addressed storage with configurable wait states,
// two-cycle ERROR responses for bad addresses and broken INCR bursts.
module ahb_sram_responder #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSel,
    input  logic        HReady,
    input  logic [31:0] HAddr,
    input  logic [1:0]  HTrans,
    input  logic        HWrite,
    input  logic [31:0] HWData,
    output logic [31:0] HRData,
    output logic        HReadyOut,
    output logic [1:0]  HResp,
    output logic [1:0]  dbg_state
);
    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t             state, state_nx;
    logic [3:0]         cnt, cnt_nx;
    logic [31:0]        mem [DEPTH];
    logic               dp_valid, dp_write;
    logic [IDX_W-1:0]   dp_idx;
    logic               prev_valid;
    logic [31:0]        prev_addr;
    logic [31:0]        hr_data;

    logic [32:0]        acc_diff;
    logic [IDX_W-1:0]   acc_idx, rd_idx;
    logic               accept, acc_err, ok_acc, err_acc;
    logic               completing, wr_en, rd_load;
    logic [31:0]        rd_word;

    // Handshake: an address phase is taken only when HSel, HReady and our own
    // HReadyOut are all high with HTrans NONSEQ/SEQ; HReadyOut low stalls the bus.
    assign accept   = HSel && HReady && HReadyOut && HTrans[1];
    // Bit 32 is the borrow, i.e. HAddr below BASE_ADDR.
    assign acc_diff = {1'b0, HAddr} - {1'b0, BASE_ADDR};
    assign acc_idx  = acc_diff[IDX_W+1:2];
    assign acc_err  = (acc_diff[1:0] != 2'b00) || acc_diff[32] ||
                      (acc_diff[31:IDX_W+2] != '0) ||
                      (HTrans[0] && (!prev_valid || HAddr != prev_addr + 32'd4));
    assign ok_acc   = accept && !acc_err;
    assign err_acc  = accept && acc_err;

    // The completion cycle is an IDLE cycle with an OKAY transfer still pending.
    assign completing = (state == ST_IDLE) && dp_valid;
    assign wr_en      = completing && dp_write;

    assign HReadyOut = (state == ST_IDLE) || (state == ST_ERR2);
    assign HResp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
    assign HRData    = hr_data;
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE, ST_ERR2: begin
                if (err_acc) begin
                    state_nx = ST_ERR1;
                end else if (ok_acc && WAIT_STATES > 0) begin
                    state_nx = ST_WAIT;
                    cnt_nx   = WS_LOAD;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) state_nx = ST_IDLE;
            end
            ST_ERR1: state_nx = ST_ERR2;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Read data is captured on the edge that opens the completion cycle; a write
    // committing on that same edge to the same word is forwarded.
    always_comb begin
        rd_load = (ok_acc && !HWrite && WAIT_STATES == 0) ||
                  ((state == ST_WAIT) && (cnt <= 4'd1) && !dp_write);
        rd_idx  = (state == ST_WAIT) ? dp_idx : acc_idx;
        rd_word = (wr_en && dp_idx == rd_idx) ? HWData : mem[rd_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            dp_idx     <= '0;
            prev_valid <= 1'b0;
            prev_addr  <= 32'd0;
        end else if (accept) begin
            dp_valid   <= !acc_err;
            dp_write   <= HWrite;
            dp_idx     <= acc_idx;
            prev_valid <= 1'b1;
            prev_addr  <= HAddr;
        end else if (completing) begin
            dp_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_data <= 32'd0;
        end else if (err_acc && !HWrite) begin
            hr_data <= 32'd0;
        end else if (rd_load) begin
            hr_data <= rd_word;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[dp_idx] <= HWData;
    end
endmodule

// File: tb/tb_ahb_sram_responder.sv
// Directed bench: one responder with a wait state, one zero-wait, driven on
// separate buses sharing clk and rst.
module tb_ahb_sram_responder;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        hsel, hready, hwrite, hreadyout;
    logic [1:0][1:0]   htrans, hresp, dbg;
    logic [1:0][31:0]  haddr, hwdata, hrdata;
    int total = 0;
    int bad   = 0;

    assign hready = hreadyout;

    ahb_sram_responder #(.DEPTH(64), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
        .clk(clk), .rst(rst), .HSel(hsel[0]), .HReady(hready[0]), .HAddr(haddr[0]),
        .HTrans(htrans[0]), .HWrite(hwrite[0]), .HWData(hwdata[0]), .HRData(hrdata[0]),
        .HReadyOut(hreadyout[0]), .HResp(hresp[0]), .dbg_state(dbg[0])
    );

    ahb_sram_responder #(.DEPTH(64), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
        .clk(clk), .rst(rst), .HSel(hsel[1]), .HReady(hready[1]), .HAddr(haddr[1]),
        .HTrans(htrans[1]), .HWrite(hwrite[1]), .HWData(hwdata[1]), .HRData(hrdata[1]),
        .HReadyOut(hreadyout[1]), .HResp(hresp[1]), .dbg_state(dbg[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag, input int d, input logic rdy, input logic [1:0] resp);
        check({tag, "_rdy"}, 32'(hreadyout[d]), 32'(rdy));
        check({tag, "_resp"}, 32'(hresp[d]), 32'(resp));
    endtask

    task automatic drive(input int d, input logic sel, input logic [1:0] tr,
                         input logic [31:0] a, input logic wr);
        hsel[d]   = sel;
        htrans[d] = tr;
        haddr[d]  = a;
        hwrite[d] = wr;
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, T_IDLE, 32'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        hsel = '0; htrans = '0; haddr = '0; hwrite = '0; hwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_bus("reset", 0, 1'b1, 2'b00);
        check("reset_rdata", hrdata[0], 32'h0);
        check("reset_state", 32'(dbg[0]), 32'd0);
        rst = 1'b0;
        step();

        // one wait state: write then read 0x10
        drive(0, 1'b1, T_NS, 32'h10, 1'b1); step();
        idle(0); hwdata[0] = 32'hDEAD_BEEF;
        check_bus("ws1_wr_wait", 0, 1'b0, 2'b00);
        check("ws1_wr_wait_state", 32'(dbg[0]), 32'd1);
        step();
        check_bus("ws1_wr_done", 0, 1'b1, 2'b00);
        drive(0, 1'b1, T_NS, 32'h10, 1'b0); step();
        idle(0);
        check_bus("ws1_rd_wait", 0, 1'b0, 2'b00);
        step();
        check_bus("ws1_rd_done", 0, 1'b1, 2'b00);
        check("ws1_rd_data", hrdata[0], 32'hDEAD_BEEF);
        step();

        // out-of-range write errors and leaves the aliased word untouched
        drive(0, 1'b1, T_NS, 32'h0, 1'b1); step();
        idle(0); hwdata[0] = 32'h1111_1111; step();
        drive(0, 1'b1, T_NS, 32'h100, 1'b1); step();
        idle(0); hwdata[0] = 32'h0000_0BAD;
        check_bus("oor_err1", 0, 1'b0, 2'b01);
        check("oor_err1_state", 32'(dbg[0]), 32'd2);
        step();
        check_bus("oor_err2", 0, 1'b1, 2'b01);
        check("oor_err2_state", 32'(dbg[0]), 32'd3);
        drive(0, 1'b1, T_NS, 32'h0, 1'b0); step();
        idle(0);
        check_bus("alias_rd_wait", 0, 1'b0, 2'b00);
        step();
        check_bus("alias_rd_done", 0, 1'b1, 2'b00);
        check("alias_rd_data", hrdata[0], 32'h1111_1111);
        step();

        // SEQ that skips an address, then an unaligned read
        drive(0, 1'b1, T_NS, 32'h0, 1'b0); step();
        idle(0); step();
        drive(0, 1'b1, T_SEQ, 32'h8, 1'b0); step();
        idle(0);
        check_bus("seq_err1", 0, 1'b0, 2'b01);
        check("seq_err_rdata", hrdata[0], 32'h0);
        step();
        check_bus("seq_err2", 0, 1'b1, 2'b01);
        step();
        drive(0, 1'b1, T_NS, 32'h10, 1'b0); step();
        idle(0); step();
        check("pre_unal_rdata", hrdata[0], 32'hDEAD_BEEF);
        drive(0, 1'b1, T_NS, 32'h3, 1'b0); step();
        idle(0);
        check_bus("unal_err1", 0, 1'b0, 2'b01);
        check("unal_err1_rdata", hrdata[0], 32'h0);
        step();
        check_bus("unal_err2", 0, 1'b1, 2'b01);
        check("unal_err2_rdata", hrdata[0], 32'h0);
        step();

        // reset during the wait state of a write discards it
        drive(0, 1'b1, T_NS, 32'h20, 1'b1); step();
        idle(0); hwdata[0] = 32'h5; step();
        step();
        drive(0, 1'b1, T_NS, 32'h20, 1'b1); step();
        idle(0); hwdata[0] = 32'h99;
        check_bus("abort_pre", 0, 1'b0, 2'b00);
        rst = 1'b1;
        #1;
        check_bus("abort_now", 0, 1'b1, 2'b00);
        check("abort_state", 32'(dbg[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b1, T_NS, 32'h20, 1'b0); step();
        idle(0); step();
        check_bus("abort_rd_done", 0, 1'b1, 2'b00);
        check("abort_rd_data", hrdata[0], 32'h5);
        step();

        // zero wait states: INCR4 write then INCR4 read
        drive(1, 1'b1, T_NS, 32'h0, 1'b1); step();
        for (int k = 0; k < 4; k++) begin
            hwdata[1] = 32'(k + 1);
            if (k < 3) drive(1, 1'b1, T_SEQ, 32'(4 * (k + 1)), 1'b1);
            else       drive(1, 1'b1, T_NS, 32'h0, 1'b0);
            check_bus($sformatf("burst_wr%0d", k), 1, 1'b1, 2'b00);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drive(1, 1'b1, T_SEQ, 32'(4 * (k + 1)), 1'b0);
            else       idle(1);
            check_bus($sformatf("burst_rd%0d", k), 1, 1'b1, 2'b00);
            check($sformatf("burst_rd%0d_data", k), hrdata[1], 32'(k + 1));
            step();
        end

        // read accepted in the completion cycle of a write to the same word
        drive(1, 1'b1, T_NS, 32'h14, 1'b1); step();
        hwdata[1] = 32'hCAFE_F00D;
        drive(1, 1'b1, T_NS, 32'h14, 1'b0); step();
        idle(1);
        check("fwd_rd_data", hrdata[1], 32'hCAFE_F00D);
        step();

        // BUSY mid-burst, then an unselected transfer
        drive(1, 1'b1, T_NS, 32'h0, 1'b0); step();
        check("busy_pre_data", hrdata[1], 32'h1);
        drive(1, 1'b1, T_BUSY, 32'h4, 1'b0); step();
        check_bus("busy_phase", 1, 1'b1, 2'b00);
        check("busy_hold", hrdata[1], 32'h1);
        drive(1, 1'b1, T_SEQ, 32'h4, 1'b0); step();
        check_bus("busy_seq", 1, 1'b1, 2'b00);
        check("busy_seq_data", hrdata[1], 32'h2);
        drive(1, 1'b0, T_NS, 32'h8, 1'b0); step();
        check_bus("unsel", 1, 1'b1, 2'b00);
        check("unsel_hold", hrdata[1], 32'h2);
        idle(1); step();

        // error latency stays two cycles with no wait states
        drive(1, 1'b1, T_NS, 32'h3, 1'b1); step();
        idle(1); hwdata[1] = 32'h77;
        check_bus("ws0_err1", 1, 1'b0, 2'b01);
        step();
        check_bus("ws0_err2", 1, 1'b1, 2'b01);
        drive(1, 1'b1, T_NS, 32'h0, 1'b0); step();
        idle(1);
        check_bus("ws0_after_err", 1, 1'b1, 2'b00);
        check("ws0_after_err_data", hrdata[1], 32'h1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
